// File: rtl/coproc_pkg.sv
// Shared constants, state encoding and element addressing for the result collector.
package coproc_pkg;

    localparam int BASE_ADDR = 14;
    localparam int NUM_WORDS = 13;
    localparam int DIM       = 5;
    localparam int ELEM_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2
    } state_t;

    // Location of one element inside the packed half-word buffer.
    typedef struct packed {
        logic [3:0] word;
        logic       hi;
    } elem_loc_t;

    // Map (row, col) onto the buffer: the row pitch is always DIM,
    // even elements sit in the high byte, odd ones in the low byte.
    function automatic elem_loc_t elem_loc(input logic [2:0] row, input logic [2:0] col);
        logic [4:0] idx;
        elem_loc_t  loc;
        idx      = 5'(row) * 5'(DIM) + 5'(col);
        loc.word = idx[4:1];
        loc.hi   = ~idx[0];
        return loc;
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// Write-back snoop bus plus the element stream towards the host consumer.
interface result_collector_if import coproc_pkg::*; ();

    logic              wb_valid;
    logic [7:0]        wb_addr;
    logic [15:0]       wb_data;

    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic [2:0]        out_row;
    logic [2:0]        out_col;
    logic              out_last;
    logic              out_ovf;

    // Driving side: coprocessor write-back plus the consumer's ready.
    modport master (
        output wb_valid, wb_addr, wb_data, out_ready,
        input  out_valid, out_data, out_row, out_col, out_last, out_ovf
    );

    // Collector side.
    modport slave (
        input  wb_valid, wb_addr, wb_data, out_ready,
        output out_valid, out_data, out_row, out_col, out_last, out_ovf
    );

endinterface

// File: rtl/result_buf_13x16.sv
// 13 x 16-bit capture buffer with a per-word written mask and combinational read.
module result_buf_13x16 import coproc_pkg::*; (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 we,
    input  logic [3:0]           waddr,
    input  logic [15:0]          wdata,
    input  logic [3:0]           raddr,
    output logic [15:0]          rdata,
    output logic [NUM_WORDS-1:0] mask
);

    logic [NUM_WORDS-1:0][15:0] words;

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            logic [15:0] word_q, word_d;
            logic        bit_q, bit_d;

            // A write to this word beats the frame-start clear so the first hit survives.
            always_comb begin
                word_d = word_q;
                bit_d  = bit_q;
                if (clr) begin
                    word_d = '0;
                    bit_d  = 1'b0;
                end
                if (we && waddr == 4'(gi)) begin
                    word_d = wdata;
                    bit_d  = 1'b1;
                end
            end

            // Word storage and its written flag.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    word_q <= '0;
                    bit_q  <= 1'b0;
                end else begin
                    word_q <= word_d;
                    bit_q  <= bit_d;
                end
            end

            assign words[gi] = word_q;
            assign mask[gi]  = bit_q;
        end
    endgenerate

    assign rdata = (raddr < 4'(NUM_WORDS)) ? words[raddr] : 16'h0000;

endmodule

// File: rtl/result_collector.sv
// Captures the coprocessor result buffer off the write-back bus and streams
// the NxN elements row-major over a valid/ready handshake.
module result_collector import coproc_pkg::*; (
    input  logic               clk,
    input  logic               reset,
    result_collector_if.slave  bus,
    input  logic [2:0]         matrix_size,
    input  logic               ovf_in,
    input  logic               clear_flags,
    output logic               busy,
    output logic               frame_err,
    output logic               size_err,
    output logic               overrun
);

    state_t            state_q, state_d;
    logic [2:0]        size_q, size_d;
    logic              ovf_q, ovf_d;
    logic [2:0]        row_q, row_d, col_q, col_d;
    logic              out_valid_q, out_valid_d;
    logic [ELEM_W-1:0] out_data_q, out_data_d;
    logic [2:0]        out_row_q, out_row_d, out_col_q, out_col_d;
    logic              out_last_q, out_last_d;
    logic              out_ovf_q, out_ovf_d;
    logic              frame_err_q, frame_err_d;
    logic              size_err_q, size_err_d;
    logic              overrun_q, overrun_d;

    logic                 hit;
    logic [3:0]           waddr;
    logic [15:0]          rdata;
    logic [NUM_WORDS-1:0] mask;
    logic [2:0]           n_eff, n_last;
    logic [2:0]           rd_row, rd_col;
    logic                 load;
    logic                 set_frame, set_size, set_ovr;
    elem_loc_t            loc;

    assign hit   = bus.wb_valid && (bus.wb_addr >= 8'(BASE_ADDR))
                                && (bus.wb_addr <= 8'(BASE_ADDR + NUM_WORDS - 1));
    assign waddr = 4'(bus.wb_addr - 8'(BASE_ADDR));

    // Oversized N is streamed as the full physical DIM.
    assign n_eff  = (size_q > 3'(DIM)) ? 3'(DIM) : size_q;
    assign n_last = n_eff - 3'd1;
    assign loc    = elem_loc(rd_row, rd_col);

    result_buf_13x16 u_buf (
        .clk   (clk),
        .reset (reset),
        .clr   (hit && state_q == IDLE),
        .we    (hit && (state_q == IDLE || state_q == CAPTURE)),
        .waddr (waddr),
        .wdata (bus.wb_data),
        .raddr (loc.word),
        .rdata (rdata),
        .mask  (mask)
    );

    // Frame FSM, stream counters and the registered output element.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        ovf_d       = ovf_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        out_ovf_d   = out_ovf_q;
        rd_row      = row_q;
        rd_col      = col_q;
        load        = 1'b0;
        set_frame   = 1'b0;
        set_size    = 1'b0;
        set_ovr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = CAPTURE;
                    size_d  = matrix_size;
                    ovf_d   = ovf_in;
                end
            end
            CAPTURE: begin
                if (!bus.wb_valid) begin
                    set_frame = ~&mask;
                    if (size_q == 3'd0) begin
                        set_size = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        set_size = (size_q > 3'(DIM));
                        state_d  = STREAM;
                        rd_row   = 3'd0;
                        rd_col   = 3'd0;
                        load     = 1'b1;
                    end
                end
            end
            STREAM: begin
                set_ovr = hit;
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        load = 1'b1;
                        if (col_q == n_last) begin
                            rd_col = 3'd0;
                            rd_row = row_q + 3'd1;
                        end else begin
                            rd_col = col_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            row_d       = rd_row;
            col_d       = rd_col;
            out_valid_d = 1'b1;
            out_data_d  = loc.hi ? rdata[15:8] : rdata[7:0];
            out_row_d   = rd_row;
            out_col_d   = rd_col;
            out_last_d  = (rd_row == n_last) && (rd_col == n_last);
            out_ovf_d   = ovf_q;
        end

        frame_err_d = (frame_err_q & ~clear_flags) | set_frame;
        size_err_d  = (size_err_q  & ~clear_flags) | set_size;
        overrun_d   = (overrun_q   & ~clear_flags) | set_ovr;
    end

    // State register; reset drops any partial frame immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            size_q      <= '0;
            ovf_q       <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            frame_err_q <= 1'b0;
            size_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            ovf_q       <= ovf_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            out_ovf_q   <= out_ovf_d;
            frame_err_q <= frame_err_d;
            size_err_q  <= size_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_ovf   = out_ovf_q;
    assign busy          = (state_q != IDLE);
    assign frame_err     = frame_err_q;
    assign size_err      = size_err_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: capture frames, stream them, check flags.
module tb_result_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] matrix_size = 3'd0;
    logic       ovf_in = 1'b0;
    logic       clear_flags = 1'b0;
    logic       busy, frame_err, size_err, overrun;

    int total = 0;
    int bad   = 0;

    logic [15:0] model [13];
    logic [7:0]  exp_data [25];
    int          exp_n;
    logic        exp_ovf;
    int          got;

    result_collector_if bus_if ();

    result_collector dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .matrix_size (matrix_size),
        .ovf_in      (ovf_in),
        .clear_flags (clear_flags),
        .busy        (busy),
        .frame_err   (frame_err),
        .size_err    (size_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] word_val(input int k);
        return {8'(2 * k + 1), 8'(2 * k + 2)};
    endfunction

    // Writes words 0..nwords-1 of a frame, each address held 4 cycles.
    task automatic send_frame(input logic [2:0] n, input logic ovf, input int nwords);
        for (int k = 0; k < 13; k++) model[k] = (k < nwords) ? word_val(k) : 16'h0000;
        for (int k = 0; k < nwords; k++) begin
            @(negedge clk);
            bus_if.wb_valid = 1'b1;
            bus_if.wb_addr  = 8'(14 + k);
            bus_if.wb_data  = word_val(k);
            matrix_size     = n;
            ovf_in          = ovf;
            repeat (3) @(negedge clk);
            if (k == 0) chk("busy_capture", 32'(busy), 32'd1);
        end
        @(negedge clk);
        bus_if.wb_valid = 1'b0;
    endtask

    // Expected element list for an NxN stream out of the model buffer.
    task automatic build_exp(input int n, input logic ovf);
        exp_n   = n;
        exp_ovf = ovf;
        for (int i = 0; i < n * n; i++) begin
            int idx;
            idx = (i / n) * 5 + (i % n);
            exp_data[i] = idx[0] ? model[idx >> 1][7:0] : model[idx >> 1][15:8];
        end
    endtask

    // Consume up to stop_after elements; toggle=1 uses ready pattern 1,0,0,1.
    task automatic collect(input int toggle, input int stop_after, input int inj_cycle, output int n_got);
        int  i = 0;
        int  cyc = 0;
        logic rdy;
        while (i < stop_after && cyc < 300) begin
            @(negedge clk);
            rdy = (toggle == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            bus_if.out_ready = rdy;
            if (cyc == inj_cycle) begin
                bus_if.wb_valid = 1'b1;
                bus_if.wb_addr  = 8'd20;
                bus_if.wb_data  = 16'hFFFF;
            end else begin
                bus_if.wb_valid = 1'b0;
            end
            if (bus_if.out_valid) begin
                chk($sformatf("data[%0d]", i), 32'(bus_if.out_data), 32'(exp_data[i]));
                chk($sformatf("row[%0d]", i),  32'(bus_if.out_row),  32'(i / exp_n));
                chk($sformatf("col[%0d]", i),  32'(bus_if.out_col),  32'(i % exp_n));
                chk($sformatf("last[%0d]", i), 32'(bus_if.out_last), 32'(i == exp_n * exp_n - 1));
                chk($sformatf("ovf[%0d]", i),  32'(bus_if.out_ovf),  32'(exp_ovf));
                if (rdy) i++;
            end
            cyc++;
        end
        if (cyc >= 300) chk("stream_timeout", 32'(i), 32'(stop_after));
        n_got = i;
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        bus_if.wb_valid  = 1'b0;
        chk({tag, "_valid_off"}, 32'(bus_if.out_valid), 32'd0);
        chk({tag, "_busy_off"},  32'(busy), 32'd0);
    endtask

    initial begin
        bus_if.wb_valid  = 1'b0;
        bus_if.wb_addr   = 8'd0;
        bus_if.wb_data   = 16'd0;
        bus_if.out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_serr",  32'(size_err), 32'd0);
        chk("rst_ovr",   32'(overrun), 32'd0);
        chk("rst_data",  32'(bus_if.out_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Out-of-range write is ignored: stays idle
        @(negedge clk);
        bus_if.wb_valid = 1'b1; bus_if.wb_addr = 8'd13; bus_if.wb_data = 16'h5555;
        @(negedge clk);
        bus_if.wb_valid = 1'b0;
        chk("oor_busy", 32'(busy), 32'd0);

        // N=3, hand-computed element table
        send_frame(3'd3, 1'b0, 13);
        exp_n = 3; exp_ovf = 1'b0;
        exp_data[0] = 8'h01; exp_data[1] = 8'h02; exp_data[2] = 8'h03;
        exp_data[3] = 8'h06; exp_data[4] = 8'h07; exp_data[5] = 8'h08;
        exp_data[6] = 8'h0B; exp_data[7] = 8'h0C; exp_data[8] = 8'h0D;
        collect(0, 9, -1, got);
        chk("n3_count", 32'(got), 32'd9);
        check_done("n3");
        chk("n3_ferr", 32'(frame_err), 32'd0);

        // N=5 with stalls and an overrun write mid-stream
        send_frame(3'd5, 1'b0, 13);
        build_exp(5, 1'b0);
        collect(1, 25, 5, got);
        chk("n5_count", 32'(got), 32'd25);
        check_done("n5");
        chk("n5_overrun", 32'(overrun), 32'd1);
        chk("n5_serr", 32'(size_err), 32'd0);

        // N=2, overflow, partial frame
        send_frame(3'd2, 1'b1, 5);
        build_exp(2, 1'b1);
        collect(0, 4, -1, got);
        chk("n2_count", 32'(got), 32'd4);
        check_done("n2");
        chk("n2_ferr", 32'(frame_err), 32'd1);

        // N=3 partial: words 5..12 unwritten, so elements 10..12 read as 0
        send_frame(3'd3, 1'b0, 5);
        build_exp(3, 1'b0);
        collect(0, 9, -1, got);
        chk("n3p_count", 32'(got), 32'd9);
        check_done("n3p");

        // N=0: size error, no stream, then clear the sticky flags
        send_frame(3'd0, 1'b0, 13);
        @(negedge clk);
        chk("n0_serr",  32'(size_err), 32'd1);
        chk("n0_busy",  32'(busy), 32'd0);
        chk("n0_valid", 32'(bus_if.out_valid), 32'd0);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("clr_serr", 32'(size_err), 32'd0);
        chk("clr_ferr", 32'(frame_err), 32'd0);
        chk("clr_ovr",  32'(overrun), 32'd0);

        // N=7: size error, streamed as 5x5
        send_frame(3'd7, 1'b0, 13);
        build_exp(5, 1'b0);
        collect(0, 25, -1, got);
        chk("n7_count", 32'(got), 32'd25);
        check_done("n7");
        chk("n7_serr", 32'(size_err), 32'd1);

        // Reset mid-stream after 3 transfers
        send_frame(3'd3, 1'b0, 13);
        build_exp(3, 1'b0);
        collect(0, 3, -1, got);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_serr",  32'(size_err), 32'd0);
        bus_if.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Full N=3 frame after reset
        send_frame(3'd3, 1'b0, 13);
        build_exp(3, 1'b0);
        collect(0, 9, -1, got);
        chk("post_rst_count", 32'(got), 32'd9);
        check_done("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
